// File: rtl/up_wishbone_classic_master_pkg.sv
// up_wishbone_classic_master_pkg: shared FSM encoding and Wishbone classic constants.
package up_wishbone_classic_master_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_WRITE
    } state_e;

    localparam logic [2:0] WB_CTI_CLASSIC = 3'b000;
    localparam logic [1:0] WB_BTE_LINEAR  = 2'b00;

endpackage

// File: rtl/up_wishbone_classic_master_timeout.sv
// up_wb_timeout: bus watchdog, flags a transfer whose strobe has waited TIMEOUT_CYCLES cycles.
module up_wb_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic clk,
    input  logic rstn,
    input  logic start,
    input  logic active,
    input  logic hit,
    output logic expired
);

    localparam int CW = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (start)
            cnt_d = '0;
        else if (active && !hit)
            cnt_d = cnt_q + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (!rstn)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    // Fires on the edge where the count would reach TIMEOUT_CYCLES, so stb stays up exactly that long
    assign expired = (TIMEOUT_CYCLES != 0) && active && !hit && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/up_wishbone_classic_master.sv
// up_wishbone_classic_master: issues single uP read/write requests as Wishbone classic master cycles.
module up_wishbone_classic_master
    import up_wishbone_classic_master_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH  = 32,
    parameter int unsigned BUS_WIDTH      = 4,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     up_rreq,
    output logic                     up_rack,
    input  logic [ADDRESS_WIDTH-1:0] up_raddr,
    output logic [BUS_WIDTH*8-1:0]   up_rdata,
    input  logic                     up_wreq,
    output logic                     up_wack,
    input  logic [ADDRESS_WIDTH-1:0] up_waddr,
    input  logic [BUS_WIDTH*8-1:0]   up_wdata,
    output logic                     bus_err,
    output logic                     m_wb_cyc,
    output logic                     m_wb_stb,
    output logic                     m_wb_we,
    output logic [ADDRESS_WIDTH-1:0] m_wb_addr,
    output logic [BUS_WIDTH*8-1:0]   m_wb_data_o,
    output logic [BUS_WIDTH-1:0]     m_wb_sel,
    output logic [2:0]               m_wb_cti,
    output logic [1:0]               m_wb_bte,
    input  logic                     m_wb_ack,
    input  logic [BUS_WIDTH*8-1:0]   m_wb_data_i,
    input  logic                     m_wb_err
);

    localparam int DW = BUS_WIDTH * 8;

    state_e                   state_q, state_d;
    logic                     rpend_q, rpend_d, wpend_q, wpend_d;
    logic [ADDRESS_WIDTH-1:0] raddr_q, raddr_d, waddr_q, waddr_d;
    logic [DW-1:0]            wdata_q, wdata_d;
    logic                     cyc_q, cyc_d, we_q, we_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [DW-1:0]            dato_q, dato_d, rdata_q, rdata_d;
    logic                     rack_q, rack_d, wack_q, wack_d, bus_err_q, bus_err_d;
    logic                     r_acc, w_acc, r_pend, w_pend, hit, expired, term, term_err, start;
    logic [ADDRESS_WIDTH-1:0] r_addr, w_addr;
    logic [DW-1:0]            w_data;

    up_wb_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
        .clk     (clk),
        .rstn    (rstn),
        .start   (start),
        .active  (cyc_q),
        .hit     (hit),
        .expired (expired)
    );

    always_comb begin
        // A request pulse may start the bus in the same edge it is accepted, bypassing the pending flop
        r_acc     = up_rreq && !rpend_q && state_q != ST_READ;
        w_acc     = up_wreq && !wpend_q && state_q != ST_WRITE;
        r_pend    = rpend_q || r_acc;
        w_pend    = wpend_q || w_acc;
        r_addr    = rpend_q ? raddr_q : up_raddr;
        w_addr    = wpend_q ? waddr_q : up_waddr;
        w_data    = wpend_q ? wdata_q : up_wdata;
        hit       = m_wb_ack || m_wb_err;
        term_err  = m_wb_err || expired;
        term      = hit || expired;
        state_d   = state_q;
        rpend_d   = r_pend;
        wpend_d   = w_pend;
        raddr_d   = r_acc ? up_raddr : raddr_q;
        waddr_d   = w_acc ? up_waddr : waddr_q;
        wdata_d   = w_acc ? up_wdata : wdata_q;
        cyc_d     = cyc_q;
        we_d      = we_q;
        addr_d    = addr_q;
        dato_d    = dato_q;
        rack_d    = 1'b0;
        wack_d    = 1'b0;
        rdata_d   = rdata_q;
        bus_err_d = bus_err_q;
        start     = 1'b0;
        if (state_q == ST_IDLE) begin
            if (w_pend) begin
                state_d = ST_WRITE;
                wpend_d = 1'b0;
                cyc_d   = 1'b1;
                we_d    = 1'b1;
                addr_d  = w_addr;
                dato_d  = w_data;
                start   = 1'b1;
            end else if (r_pend) begin
                state_d = ST_READ;
                rpend_d = 1'b0;
                cyc_d   = 1'b1;
                we_d    = 1'b0;
                addr_d  = r_addr;
                start   = 1'b1;
            end
        end else if (term) begin
            state_d   = ST_IDLE;
            cyc_d     = 1'b0;
            we_d      = 1'b0;
            rack_d    = state_q == ST_READ;
            wack_d    = state_q == ST_WRITE;
            rdata_d   = (state_q == ST_READ) ? (term_err ? '0 : m_wb_data_i) : rdata_q;
            bus_err_d = bus_err_q || term_err;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= ST_IDLE;
            rpend_q   <= 1'b0;
            wpend_q   <= 1'b0;
            raddr_q   <= '0;
            waddr_q   <= '0;
            wdata_q   <= '0;
            cyc_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            dato_q    <= '0;
            rack_q    <= 1'b0;
            wack_q    <= 1'b0;
            rdata_q   <= '0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rpend_q   <= rpend_d;
            wpend_q   <= wpend_d;
            raddr_q   <= raddr_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
            cyc_q     <= cyc_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            dato_q    <= dato_d;
            rack_q    <= rack_d;
            wack_q    <= wack_d;
            rdata_q   <= rdata_d;
            bus_err_q <= bus_err_d;
        end
    end

    assign up_rack     = rack_q;
    assign up_wack     = wack_q;
    assign up_rdata    = rdata_q;
    assign bus_err     = bus_err_q;
    assign m_wb_cyc    = cyc_q;
    assign m_wb_stb    = cyc_q;
    assign m_wb_we     = we_q;
    assign m_wb_addr   = addr_q;
    assign m_wb_data_o = dato_q;
    assign m_wb_sel    = {BUS_WIDTH{1'b1}};
    assign m_wb_cti    = WB_CTI_CLASSIC;
    assign m_wb_bte    = WB_BTE_LINEAR;

endmodule
